// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full_adder cell, carry flop, LSB-first shift registers

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_accept;
  logic             w_out_fire;

  full_adder u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign w_acc_nxt = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_out_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = in_valid;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_fire = out_ready;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a_sr  <= a;
        r_b_sr  <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end
      if (r_state == S_RUN) begin
        r_a_sr  <= r_a_sr >> 1;
        r_b_sr  <= r_b_sr >> 1;
        r_acc   <= w_acc_nxt;
        r_carry <= w_c;
        r_cnt   <= r_cnt + CW'(1);
        // Output registers only change on completion, so they hold across the next RUN
        if (w_last) begin
          r_sum       <= w_acc_nxt;
          r_cout      <= w_c;
          r_out_valid <= 1'b1;
        end
      end
      if (w_out_fire) r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds)

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;
  logic       p1_in_valid, p1_in_ready, p1_cin, p1_out_valid, p1_out_ready, p1_cout, p1_busy;
  logic [0:0] p1_a, p1_b, p1_sum;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  int n_ops   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(1), .CW(2)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .a(p1_a), .b(p1_b), .cin(p1_cin), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
    .sum(p1_sum), .cout(p1_cout), .busy(p1_busy)
  );

  always @(negedge clk) begin
    if (in_valid && in_ready) n_acc++;
    if (out_valid && out_ready) n_out++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                        input int hold, input bit churn,
                        output logic [7:0] osum, output logic ocout);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; cin = tcin; in_valid = 1'b1;
    tick;
    n_ops++;
    if (!churn) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (churn) begin a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); end
      tick;
      n++;
    end
    check("latency", n, 8);
    check("in_ready_done", in_ready, 0);
    check("busy_done", busy, 1);
    osum  = sum;
    ocout = cout;
    for (int i = 0; i < hold; i++) begin
      if (churn) begin a = 8'($urandom); b = 8'($urandom); end
      tick;
      check("hold_valid", out_valid, 1);
      check("hold_data", {cout, sum}, {ocout, osum});
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick;
    out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    int         hold;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] r_s;
  logic       r_c;
  logic [8:0] exp9;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 6};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    p1_in_valid = 1'b0; p1_out_ready = 1'b0; p1_a = '0; p1_b = '0; p1_cin = 1'b0;
    tick;
    check("rst_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", {cout, sum}, 9'h000);
    check("rst_busy", busy, 0);
    check("rst_in_ready_rel", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].hold, 1'b0, r_s, r_c);
      check($sformatf("vec%0d_sum", i), r_s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), r_c, vecs[i].co);
    end

    run_op(8'h12, 8'h34, 1'b1, 2, 1'b1, r_s, r_c);
    check("churn_result", {r_c, r_s}, 9'h047);

    // Abandon 0xAA+0x55 partway through RUN
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_forces_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", {cout, sum}, 9'h000);
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      tick;
      check("abort_no_result", out_valid, 0);
    end
    run_op(8'h01, 8'h02, 1'b0, 0, 1'b0, r_s, r_c);
    check("post_abort", {r_c, r_s}, 9'h003);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      run_op(ra, rb, rc, i % 3, 1'b0, r_s, r_c);
      check("rand", {r_c, r_s}, exp9);
    end

    check("accept_count", n_acc, n_ops + 1);
    check("result_count", n_out, n_ops);

    p1_a = 1'b1; p1_b = 1'b1; p1_cin = 1'b1; p1_in_valid = 1'b1;
    check("w1_in_ready", p1_in_ready, 1);
    tick;
    p1_in_valid = 1'b0;
    check("w1_run", p1_out_valid, 0);
    tick;
    check("w1_valid", p1_out_valid, 1);
    check("w1_result", {p1_cout, p1_sum}, 2'b11);
    p1_out_ready = 1'b1;
    tick;
    p1_out_ready = 1'b0;
    check("w1_clr", p1_out_valid, 0);
    p1_a = 1'b1; p1_b = 1'b0; p1_cin = 1'b0; p1_in_valid = 1'b1;
    tick;
    p1_in_valid = 1'b0;
    tick;
    check("w1_result2", {p1_out_valid, p1_cout, p1_sum}, 3'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
